// File: rtl/seq_detect_ctrl_pkg.sv
// Shared types and defaults for the two-slot serial pattern detector controller.
package seq_ctrl_pkg;

  localparam int SEQ_MAX_LEN = 8;
  localparam int SEQ_LEN_W   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    HOLD  = 2'd2
  } state_e;

  // One detector slot; len of 0 or above SEQ_MAX_LEN leaves the slot disabled.
  typedef struct packed {
    logic [SEQ_MAX_LEN-1:0] pattern;
    logic [SEQ_LEN_W-1:0]   len;
  } slot_cfg_t;

endpackage

// File: rtl/seq_detect_ctrl_if.sv
// Serial bit input and match-event output handshakes of the detector controller.
interface seq_detect_ctrl_if;
  logic       din_valid;
  logic       din;
  logic       din_ready;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_id;

  // Bit source / event sink side
  modport master (
    output din_valid, din, evt_ready,
    input  din_ready, evt_valid, evt_id
  );

  // Controller side
  modport slave (
    input  din_valid, din, evt_ready,
    output din_ready, evt_valid, evt_id
  );
endinterface

// File: rtl/seq_detect_ctrl_slot.sv
// Combinational compare of one pattern slot against the shared history register.
module pattern_match_slot
  import seq_ctrl_pkg::*;
#(
  parameter int MAX_LEN = SEQ_MAX_LEN,
  parameter int LEN_W   = SEQ_LEN_W
) (
  input  logic [MAX_LEN-1:0] history,
  input  logic [LEN_W-1:0]   bits_seen,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  output logic               hit
);

  logic [MAX_LEN-1:0] len_mask;
  logic               enabled;

  // Only the low len bits take part; an empty mask must never count as a match.
  always_comb begin
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (LEN_W'(i) < len);
    end
    enabled = (len != '0) && (len <= LEN_W'(MAX_LEN));
    hit     = enabled && (bits_seen >= len) &&
              (((history ^ pattern) & len_mask) == '0);
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Two-slot programmable serial pattern detector: arm/disarm FSM, shared history,
// match event port and saturating per-slot counters.
//
//  state | meaning
//  IDLE  | disarmed, slot config writable, no bits accepted
//  ARMED | accepting bits and matching both slots
//  HOLD  | match event pending, input stalled until the sink takes it
module seq_detect_ctrl
  import seq_ctrl_pkg::*;
#(
  parameter int MAX_LEN = SEQ_MAX_LEN,
  parameter int LEN_W   = SEQ_LEN_W,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_we,
  input  logic               cfg_sel,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               start,
  input  logic               stop,
  seq_detect_ctrl_if.slave   bus,
  output logic [CNT_W-1:0]   match_cnt0,
  output logic [CNT_W-1:0]   match_cnt1,
  output logic               busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e             state_q, state_d;
  logic [MAX_LEN-1:0] hist_q, hist_d, hist_new;
  logic [LEN_W-1:0]   bits_q, bits_d, bits_new;
  logic               evt_valid_q, evt_valid_d;
  logic [1:0]         evt_id_q, evt_id_d;
  logic [CNT_W-1:0]   cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic               overlap_q, overlap_d;
  slot_cfg_t          slot_q [2];
  slot_cfg_t          slot_d [2];
  logic [1:0]         hit;

  // History and fill level as they would look after taking the bit on the bus.
  always_comb begin
    hist_new = {hist_q[MAX_LEN-2:0], bus.din};
    bits_new = (bits_q == LEN_W'(MAX_LEN)) ? bits_q : bits_q + LEN_W'(1);
  end

  for (genvar k = 0; k < 2; k++) begin : g_slot
    pattern_match_slot #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) u_slot (
      .history   (hist_new),
      .bits_seen (bits_new),
      .pattern   (slot_q[k].pattern),
      .len       (slot_q[k].len),
      .hit       (hit[k])
    );
  end

  // Next-state, datapath updates and counters.
  always_comb begin
    state_d     = state_q;
    hist_d      = hist_q;
    bits_d      = bits_q;
    evt_valid_d = evt_valid_q;
    evt_id_d    = evt_id_q;
    cnt0_d      = cnt0_q;
    cnt1_d      = cnt1_q;
    overlap_d   = overlap_q;
    slot_d      = slot_q;

    case (state_q)
      IDLE: begin
        if (cfg_we) begin
          slot_d[cfg_sel] = '{pattern: cfg_pattern, len: cfg_len};
        end
        if (start && !stop) begin
          hist_d    = '0;
          bits_d    = '0;
          cnt0_d    = '0;
          cnt1_d    = '0;
          overlap_d = cfg_overlap;
          state_d   = ARMED;
        end
      end
      ARMED: begin
        if (stop) begin
          state_d = IDLE;
        end else if (bus.din_valid) begin
          hist_d = hist_new;
          bits_d = bits_new;
          if (|hit) begin
            evt_valid_d = 1'b1;
            evt_id_d    = hit;
            if (hit[0] && cnt0_q != CNT_MAX) cnt0_d = cnt0_q + CNT_W'(1);
            if (hit[1] && cnt1_q != CNT_MAX) cnt1_d = cnt1_q + CNT_W'(1);
            // Non-overlapping mode restarts the fill so hitting bits are not reused.
            if (!overlap_q) bits_d = '0;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (stop) begin
          evt_valid_d = 1'b0;
          state_d     = IDLE;
        end else if (bus.evt_ready) begin
          evt_valid_d = 1'b0;
          state_d     = ARMED;
        end
      end
      default: begin
        evt_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      hist_q      <= '0;
      bits_q      <= '0;
      evt_valid_q <= 1'b0;
      evt_id_q    <= '0;
      cnt0_q      <= '0;
      cnt1_q      <= '0;
      overlap_q   <= 1'b0;
      slot_q[0]   <= '0;
      slot_q[1]   <= '0;
    end else begin
      state_q     <= state_d;
      hist_q      <= hist_d;
      bits_q      <= bits_d;
      evt_valid_q <= evt_valid_d;
      evt_id_q    <= evt_id_d;
      cnt0_q      <= cnt0_d;
      cnt1_q      <= cnt1_d;
      overlap_q   <= overlap_d;
      slot_q[0]   <= slot_d[0];
      slot_q[1]   <= slot_d[1];
    end
  end

  assign bus.din_ready = (state_q == ARMED);
  assign bus.evt_valid = evt_valid_q;
  assign bus.evt_id    = evt_id_q;
  assign match_cnt0    = cnt0_q;
  assign match_cnt1    = cnt1_q;
  assign busy          = (state_q != IDLE);

endmodule
